// File: rtl/register_file_sb_if.sv
// Decode-stage register file bus: writeback, issue and the two operand read ports.
// The master is the pipeline; the slave is the register file.
interface register_file_sb_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  issue_en;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [ADDR_WIDTH-1:0] rd_addr_rs;
  logic [ADDR_WIDTH-1:0] rd_addr_rt;
  logic [DATA_WIDTH-1:0] data_out_rs;
  logic [DATA_WIDTH-1:0] data_out_rt;
  logic                  busy_rs;
  logic                  busy_rt;
  logic [ADDR_WIDTH:0]   pending_cnt;

  modport master (
    output w_en, waddr, data_in, issue_en, issue_addr, rd_addr_rs, rd_addr_rt,
    input  data_out_rs, data_out_rt, busy_rs, busy_rt, pending_cnt
  );

  modport slave (
    input  w_en, waddr, data_in, issue_en, issue_addr, rd_addr_rs, rd_addr_rt,
    output data_out_rs, data_out_rt, busy_rs, busy_rt, pending_cnt
  );
endinterface

// File: rtl/register_file_sb.sv
// Two-read/one-write register file with a per-register pending scoreboard,
// optional hardwired zero register, writeback bypass and a pending-register count.
module register_file_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned RESET_MODE = 0
) (
  input logic               clock,
  input logic               reset,
  register_file_sb_if.slave bus
);

  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam int unsigned NPORTS = 2;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic [CNT_W-1:0]      cnt;

  logic wr_ok;
  logic issue_ok;
  logic cnt_inc;
  logic cnt_dec;

  logic [ADDR_WIDTH-1:0] raddr [NPORTS];
  logic [DATA_WIDTH-1:0] rdata [NPORTS];
  logic                  rbusy [NPORTS];

  // Accesses aimed at a hardwired zero register are dropped entirely.
  assign wr_ok    = bus.w_en     && !((ZERO_REG != 0) && (bus.waddr == ZERO_ADDR));
  assign issue_ok = bus.issue_en && !((ZERO_REG != 0) && (bus.issue_addr == ZERO_ADDR));

  // A register only enters the count when it was idle; a same-address write never
  // retires an issue landing on the same edge.
  assign cnt_inc = issue_ok && !busy[bus.issue_addr];
  assign cnt_dec = wr_ok && busy[bus.waddr] && !(issue_ok && (bus.issue_addr == bus.waddr));

  // Scoreboard next state: clear on writeback, then set on issue so set wins.
  always_comb begin
    busy_next = busy;
    if (wr_ok) begin
      busy_next[bus.waddr] = 1'b0;
    end
    if (issue_ok) begin
      busy_next[bus.issue_addr] = 1'b1;
    end
  end

  // Storage, scoreboard and pending count; reset overrides any same-cycle traffic.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= (RESET_MODE == 1) ? DATA_WIDTH'(i) : '0;
      end
      busy <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok) begin
        mem[bus.waddr] <= bus.data_in;
      end
      busy <= busy_next;
      cnt  <= cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    end
  end

  assign raddr[0] = bus.rd_addr_rs;
  assign raddr[1] = bus.rd_addr_rt;

  // Independent combinational read ports with writeback forwarding and zero override.
  always_comb begin
    for (int unsigned p = 0; p < NPORTS; p++) begin
      rdata[p] = mem[raddr[p]];
      rbusy[p] = busy[raddr[p]];
      if ((BYPASS != 0) && wr_ok && (bus.waddr == raddr[p])) begin
        rdata[p] = bus.data_in;
        rbusy[p] = issue_ok && (bus.issue_addr == raddr[p]);
      end
      if ((ZERO_REG != 0) && (raddr[p] == ZERO_ADDR)) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end
    end
  end

  assign bus.data_out_rs = rdata[0];
  assign bus.data_out_rt = rdata[1];
  assign bus.busy_rs     = rbusy[0];
  assign bus.busy_rt     = rbusy[1];
  assign bus.pending_cnt = cnt;

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: two configurations driven in lockstep and checked
// against an array-based model of the register file and scoreboard.
module tb_register_file_sb;

  logic        clock;
  logic        reset;
  logic        w_en;
  logic [4:0]  waddr;
  logic [31:0] data_in;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [4:0]  rs;
  logic [4:0]  rt;

  int n_checks;
  int n_pass;

  // Config A: zero reg, bypass, reset to index. Config B: no zero reg, no bypass, reset to 0.
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  bit          ba [32];
  bit          bb [32];

  register_file_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_a ();
  register_file_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_b ();

  assign bus_a.w_en = w_en;         assign bus_b.w_en = w_en;
  assign bus_a.waddr = waddr;       assign bus_b.waddr = waddr;
  assign bus_a.data_in = data_in;   assign bus_b.data_in = data_in;
  assign bus_a.issue_en = issue_en; assign bus_b.issue_en = issue_en;
  assign bus_a.issue_addr = issue_addr; assign bus_b.issue_addr = issue_addr;
  assign bus_a.rd_addr_rs = rs;     assign bus_b.rd_addr_rs = rs;
  assign bus_a.rd_addr_rt = rt;     assign bus_b.rd_addr_rt = rt;

  register_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1), .RESET_MODE(1))
    dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  register_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0), .RESET_MODE(0))
    dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected {busy, data} on one read port for the selected configuration.
  function automatic logic [32:0] exp_port(bit is_a, logic [4:0] addr);
    if (is_a && addr == 5'd0) return 33'd0;
    if (is_a && w_en && waddr == addr) return {issue_en && issue_addr == addr, data_in};
    return is_a ? {ba[addr], ma[addr]} : {bb[addr], mb[addr]};
  endfunction

  function automatic int pop(bit is_a);
    int n = 0;
    for (int i = 0; i < 32; i++) n += is_a ? int'(ba[i]) : int'(bb[i]);
    return n;
  endfunction

  function automatic logic [71:0] exp_all(bit is_a);
    return {exp_port(is_a, rs), exp_port(is_a, rt), 6'(pop(is_a))};
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic cycle();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        ma[i] = 32'(i); mb[i] = 32'd0; ba[i] = 1'b0; bb[i] = 1'b0;
      end
    end else begin
      if (w_en && waddr != 5'd0) begin ma[waddr] = data_in; ba[waddr] = 1'b0; end
      if (w_en) begin mb[waddr] = data_in; bb[waddr] = 1'b0; end
      if (issue_en && issue_addr != 5'd0) ba[issue_addr] = 1'b1;
      if (issue_en) bb[issue_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; w_en = 1'b0; waddr = '0; data_in = '0;
    issue_en = 1'b0; issue_addr = '0; rs = '0; rt = '0;
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; cycle(); reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rs = 5'd5; rt = 5'd31; #1;
    n_checks++; if (bus_a.data_out_rs !== 32'd5) $display("FAIL reset_rs: got %h want %h", bus_a.data_out_rs, 32'd5); else n_pass++;
    n_checks++; if (bus_a.data_out_rt !== 32'd31) $display("FAIL reset_rt: got %h want %h", bus_a.data_out_rt, 32'd31); else n_pass++;
    n_checks++; if ({bus_a.busy_rs, bus_a.busy_rt} !== 2'b00) $display("FAIL reset_busy: got %b want 00", {bus_a.busy_rs, bus_a.busy_rt}); else n_pass++;
    n_checks++; if (bus_a.pending_cnt !== 6'd0) $display("FAIL reset_cnt: got %0d want 0", bus_a.pending_cnt); else n_pass++;
    n_checks++; if (bus_b.data_out_rs !== 32'd0) $display("FAIL reset_b_rs: got %h want 0", bus_b.data_out_rs); else n_pass++;
  endtask

  task automatic test_zero_reg();
    idle(); w_en = 1'b1; waddr = 5'd3; data_in = 32'h0000_abcd; cycle();
    idle(); rs = 5'd3; rt = 5'd0; #1;
    n_checks++; if (bus_a.data_out_rs !== 32'h0000_abcd) $display("FAIL zero_rs3: got %h want %h", bus_a.data_out_rs, 32'h0000_abcd); else n_pass++;
    n_checks++; if (bus_a.data_out_rt !== 32'd0) $display("FAIL zero_rt0: got %h want 0", bus_a.data_out_rt); else n_pass++;
    w_en = 1'b1; waddr = 5'd0; data_in = 32'h0000_dead; rs = 5'd0; #1;
    n_checks++; if (bus_a.data_out_rs !== 32'd0) $display("FAIL zero_nobypass: got %h want 0", bus_a.data_out_rs); else n_pass++;
    cycle(); idle(); rs = 5'd0; #1;
    n_checks++; if (bus_a.data_out_rs !== 32'd0) $display("FAIL zero_after_write: got %h want 0", bus_a.data_out_rs); else n_pass++;
    n_checks++; if (bus_b.data_out_rs !== 32'h0000_dead) $display("FAIL b_reg0_write: got %h want %h", bus_b.data_out_rs, 32'h0000_dead); else n_pass++;
  endtask

  task automatic test_bypass();
    idle(); w_en = 1'b1; waddr = 5'd7; data_in = 32'h0000_1234; rs = 5'd7; rt = 5'd7; #1;
    n_checks++; if (bus_a.data_out_rs !== 32'h0000_1234) $display("FAIL bypass_same: got %h want %h", bus_a.data_out_rs, 32'h0000_1234); else n_pass++;
    n_checks++; if (bus_b.data_out_rs !== 32'd0) $display("FAIL nobypass_old: got %h want 0", bus_b.data_out_rs); else n_pass++;
    cycle(); idle(); rs = 5'd7; #1;
    n_checks++; if (bus_b.data_out_rs !== 32'h0000_1234) $display("FAIL nobypass_next: got %h want %h", bus_b.data_out_rs, 32'h0000_1234); else n_pass++;
  endtask

  task automatic test_scoreboard();
    do_reset();
    issue_en = 1'b1; issue_addr = 5'd4; cycle();
    issue_addr = 5'd9; cycle();
    idle(); rs = 5'd4; rt = 5'd9; #1;
    n_checks++; if (bus_a.pending_cnt !== 6'd2) $display("FAIL sb_cnt2: got %0d want 2", bus_a.pending_cnt); else n_pass++;
    n_checks++; if ({bus_a.busy_rs, bus_a.busy_rt} !== 2'b11) $display("FAIL sb_busy: got %b want 11", {bus_a.busy_rs, bus_a.busy_rt}); else n_pass++;
    w_en = 1'b1; waddr = 5'd4; data_in = 32'h55; cycle();
    idle(); rs = 5'd4; rt = 5'd9; #1;
    n_checks++; if (bus_a.busy_rs !== 1'b0) $display("FAIL sb_clear: got %b want 0", bus_a.busy_rs); else n_pass++;
    n_checks++; if (bus_a.pending_cnt !== 6'd1) $display("FAIL sb_cnt1: got %0d want 1", bus_a.pending_cnt); else n_pass++;
    issue_en = 1'b1; issue_addr = 5'd9; cycle();
    idle(); rt = 5'd9; #1;
    n_checks++; if (bus_a.pending_cnt !== 6'd1) $display("FAIL sb_reissue: got %0d want 1", bus_a.pending_cnt); else n_pass++;
  endtask

  task automatic test_same_addr();
    do_reset();
    issue_en = 1'b1; issue_addr = 5'd6; cycle();
    w_en = 1'b1; waddr = 5'd6; data_in = 32'h66; rs = 5'd6; #1;
    n_checks++; if (bus_a.busy_rs !== 1'b1) $display("FAIL same_bypass_busy: got %b want 1", bus_a.busy_rs); else n_pass++;
    n_checks++; if (bus_b.busy_rs !== 1'b1) $display("FAIL same_stored_busy: got %b want 1", bus_b.busy_rs); else n_pass++;
    cycle(); idle(); rs = 5'd6; #1;
    n_checks++; if ({bus_a.busy_rs, bus_a.pending_cnt} !== {1'b1, 6'd1}) $display("FAIL same_busy_hold: got %b/%0d want 1/1", bus_a.busy_rs, bus_a.pending_cnt); else n_pass++;
    issue_en = 1'b1; issue_addr = 5'd8; w_en = 1'b1; waddr = 5'd6; cycle();
    idle(); rs = 5'd6; rt = 5'd8; #1;
    n_checks++; if ({bus_a.busy_rs, bus_a.busy_rt, bus_a.pending_cnt} !== {2'b01, 6'd1}) $display("FAIL diff_net0: got %b%b/%0d want 01/1", bus_a.busy_rs, bus_a.busy_rt, bus_a.pending_cnt); else n_pass++;
    do_reset();
    issue_en = 1'b1; issue_addr = 5'd6; w_en = 1'b1; waddr = 5'd6; cycle();
    idle(); rs = 5'd6; #1;
    n_checks++; if ({bus_a.busy_rs, bus_a.pending_cnt} !== {1'b1, 6'd1}) $display("FAIL same_idle_set: got %b/%0d want 1/1", bus_a.busy_rs, bus_a.pending_cnt); else n_pass++;
  endtask

  task automatic test_fill_reset();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      issue_en = 1'b1; issue_addr = 5'(i); cycle();
    end
    idle(); #1;
    n_checks++; if (bus_a.pending_cnt !== 6'd31) $display("FAIL fill_a: got %0d want 31", bus_a.pending_cnt); else n_pass++;
    n_checks++; if (bus_b.pending_cnt !== 6'd32) $display("FAIL fill_b: got %0d want 32", bus_b.pending_cnt); else n_pass++;
    n_checks++; if ({bus_a.busy_rs, bus_b.busy_rs} !== 2'b01) $display("FAIL fill_reg0: got %b want 01", {bus_a.busy_rs, bus_b.busy_rs}); else n_pass++;
    reset = 1'b1; w_en = 1'b1; waddr = 5'd5; data_in = 32'hffff; issue_en = 1'b1; issue_addr = 5'd5; cycle();
    idle(); rs = 5'd5; rt = 5'd31; #1;
    n_checks++; if ({bus_a.pending_cnt, bus_b.pending_cnt} !== 12'd0) $display("FAIL midreset_cnt: got %0d/%0d want 0/0", bus_a.pending_cnt, bus_b.pending_cnt); else n_pass++;
    n_checks++; if ({bus_a.busy_rs, bus_a.busy_rt, bus_b.busy_rs} !== 3'b000) $display("FAIL midreset_busy: got %b want 000", {bus_a.busy_rs, bus_a.busy_rt, bus_b.busy_rs}); else n_pass++;
    n_checks++; if (bus_a.data_out_rs !== 32'd5) $display("FAIL midreset_a_rs: got %h want 5", bus_a.data_out_rs); else n_pass++;
    n_checks++; if (bus_b.data_out_rs !== 32'd0) $display("FAIL midreset_b_rs: got %h want 0", bus_b.data_out_rs); else n_pass++;
  endtask

  task automatic test_random();
    logic [71:0] got;
    logic [71:0] want;
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 39) == 0);
      w_en       = $urandom_range(0, 1) == 1;
      waddr      = 5'($urandom_range(0, 31));
      data_in    = $urandom;
      issue_en   = $urandom_range(0, 2) != 0;
      issue_addr = 5'($urandom_range(0, 31));
      rs         = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      rt         = ($urandom_range(0, 3) == 0) ? issue_addr : 5'($urandom_range(0, 31));
      #1;
      got  = {bus_a.busy_rs, bus_a.data_out_rs, bus_a.busy_rt, bus_a.data_out_rt, bus_a.pending_cnt};
      want = exp_all(1'b1);
      n_checks++; if (got !== want) $display("FAIL rand_a[%0d]: got %h want %h", n, got, want); else n_pass++;
      got  = {bus_b.busy_rs, bus_b.data_out_rs, bus_b.busy_rt, bus_b.data_out_rt, bus_b.pending_cnt};
      want = exp_all(1'b0);
      n_checks++; if (got !== want) $display("FAIL rand_b[%0d]: got %h want %h", n, got, want); else n_pass++;
      cycle();
    end
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    idle();
    @(negedge clock);
    test_reset();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_same_addr();
    test_fill_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
